// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage ahead of the IF/ID register.
// Keeps the PC, assembles each 32-bit word from a byte-wide memory port,
// redirects on jumps and holds its output while the pipeline is stalled.
// Optional direct-mapped instruction cache: define ICACHE_EN to build it in.
module inst_fetch #(
    parameter int          ICACHE_LINES = 64,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic        stall_i,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_byte_i,
    input  logic        mem_byte_valid_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ABORT} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [23:0] low_bytes;
    logic [31:0] fetched_word;
    logic        hit;
    logic [31:0] hit_word;
    logic        byte_take;
    logic        last_byte;
    logic        issue;
    logic        present_hit;
    logic        present_fetch;
    logic        hold_keep;

    // The fourth byte completes the word straight from the input port.
    assign fetched_word = {mem_byte_i, low_bytes};

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             data_mem [ICACHE_LINES];
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_valid;
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        wr_idx;

    assign rd_idx = pc[IDX_W+1:2];
    assign wr_idx = mem_addr_o[IDX_W+1:2];

    // Lookup of the current PC against its line.
    always_comb begin
        hit      = line_valid[rd_idx] && (tag_mem[rd_idx] == pc[31:IDX_W+2]);
        hit_word = data_mem[rd_idx];
    end

    // Every completed miss fills its line, even when a jump discards the word.
    always_ff @(posedge clk_in) begin
        if (last_byte) begin
            data_mem[wr_idx] <= fetched_word;
            tag_mem[wr_idx]  <= mem_addr_o[31:IDX_W+2];
        end
    end

    // Valid bits are only ever cleared by reset.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            line_valid <= '0;
        end else if (last_byte) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end
`else
    logic [31:0] unused_lines;

    assign unused_lines = ICACHE_LINES;
    assign hit          = 1'b0;
    assign hit_word     = '0;
`endif

    // State register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a jump overrides everything, FETCH must pass through ABORT.
    always_comb begin
        next_state = state;
        if (jump_enable_i) begin
            next_state = (state == FETCH) ? ABORT : IDLE;
        end else begin
            case (state)
                IDLE:    if (!stall_i && !hit) next_state = FETCH;
                FETCH:   if (last_byte) next_state = stall_i ? HOLD : IDLE;
                HOLD:    if (!stall_i) next_state = IDLE;
                ABORT:   next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Control strobes decoded from state and inputs.
    always_comb begin
        byte_take     = (state == FETCH) && mem_req_o && mem_byte_valid_i;
        last_byte     = byte_take && (count == 2'd3);
        issue         = !jump_enable_i && !stall_i && (state == IDLE) && !hit;
        present_hit   = !jump_enable_i && !stall_i && (state == IDLE) && hit;
        present_fetch = !jump_enable_i && last_byte;
        hold_keep     = !jump_enable_i && (state == HOLD) && stall_i;
    end

    // Datapath registers: PC, memory request, byte assembly and output word.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            pc           <= RESET_PC;
            count        <= '0;
            low_bytes    <= '0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            inst_o       <= '0;
            pc_o         <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            inst_valid_o <= present_hit || present_fetch || hold_keep;

            if (jump_enable_i) begin
                pc <= jump_pc_i;
            end else if (present_hit || present_fetch) begin
                pc <= pc + 32'd4;
            end

            if (issue) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= {pc[31:2], 2'b00};
            end else if (jump_enable_i || last_byte) begin
                mem_req_o <= 1'b0;
            end

            if (jump_enable_i) begin
                count <= '0;
            end else if (byte_take) begin
                count <= count + 2'd1;
            end

            if (byte_take) begin
                case (count)
                    2'd0:    low_bytes[7:0]   <= mem_byte_i;
                    2'd1:    low_bytes[15:8]  <= mem_byte_i;
                    2'd2:    low_bytes[23:16] <= mem_byte_i;
                    default: ;
                endcase
            end

            if (present_hit) begin
                inst_o <= hit_word;
                pc_o   <= pc;
            end else if (present_fetch) begin
                inst_o <= fetched_word;
                pc_o   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch. A second instance with
// RESET_PC = 32'hFFFFFFFC covers PC wrap-around. Cache checks follow ICACHE_EN.
module tb_inst_fetch;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic [7:0]  mem_byte;
    logic        mem_byte_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;

    logic        w_stall;
    logic        w_jump_en;
    logic [31:0] w_jump_pc;
    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic [31:0] w_pc_out;
    logic        w_inst_valid;

    int vectors;
    int miscompares;

    inst_fetch #(.ICACHE_LINES(64), .RESET_PC(32'h0)) dut (
        .clk_in           (clk),
        .rstn_in          (rstn),
        .stall_i          (stall),
        .jump_enable_i    (jump_en),
        .jump_pc_i        (jump_pc),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_byte_i       (mem_byte),
        .mem_byte_valid_i (mem_byte_valid),
        .inst_o           (inst),
        .pc_o             (pc_out),
        .inst_valid_o     (inst_valid)
    );

    inst_fetch #(.ICACHE_LINES(64), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk_in           (clk),
        .rstn_in          (rstn),
        .stall_i          (w_stall),
        .jump_enable_i    (w_jump_en),
        .jump_pc_i        (w_jump_pc),
        .mem_req_o        (w_req),
        .mem_addr_o       (w_addr),
        .mem_byte_i       (w_byte),
        .mem_byte_valid_i (w_byte_valid),
        .inst_o           (w_inst),
        .pc_o             (w_pc_out),
        .inst_valid_o     (w_inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: outputs are sampled and inputs changed at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Feed n bytes of word w, little-endian, one per cycle.
    task automatic send_bytes(input logic [31:0] w, input int n, input bit wrap);
        for (int i = 0; i < n; i++) begin
            if (wrap) begin
                w_byte       = w[8*i +: 8];
                w_byte_valid = 1'b1;
            end else begin
                mem_byte       = w[8*i +: 8];
                mem_byte_valid = 1'b1;
            end
            cyc();
        end
        mem_byte_valid = 1'b0;
        w_byte_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) cyc();
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req);
        end
        vectors++;
        if (mem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_addr: got %h expected 00000000", mem_addr);
        end
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_inst: got %h expected 00000000", inst);
        end
        vectors++;
        if (pc_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_pc: got %h expected 00000000", pc_out);
        end
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid);
        end
    endtask

    task automatic test_first_fetch();
        rstn = 1'b1;
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr);
        end
        cyc();
        send_bytes(32'h00000013, 4, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || pc_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL first_inst: got valid=%b inst=%h pc=%h expected 1 00000013 00000000", inst_valid, inst, pc_out);
        end
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL first_req_drop: got %b expected 0", mem_req);
        end
        cyc();
        vectors++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            miscompares++; $display("[TB] FAIL next_addr: got valid=%b req=%b addr=%h expected 0 1 00000004", inst_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_stall();
        cyc();
        send_bytes(32'h00A00093, 3, 1'b0);
        stall          = 1'b1;
        mem_byte       = 8'h00;
        mem_byte_valid = 1'b1;
        cyc();
        mem_byte_valid = 1'b0;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00A00093 || pc_out !== 32'h4) begin
            miscompares++; $display("[TB] FAIL stall_present: got valid=%b inst=%h pc=%h expected 1 00a00093 00000004", inst_valid, inst, pc_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (inst_valid !== 1'b1 || inst !== 32'h00A00093 || pc_out !== 32'h4 || mem_req !== 1'b0) begin
                miscompares++; $display("[TB] FAIL stall_hold%0d: got valid=%b inst=%h pc=%h req=%b expected 1 00a00093 00000004 0", i, inst_valid, inst, pc_out, mem_req);
            end
        end
        stall = 1'b0;
        cyc();
        vectors++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL stall_release: got valid=%b req=%b expected 0 0", inst_valid, mem_req);
        end
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            miscompares++; $display("[TB] FAIL stall_pc_once: got req=%b addr=%h expected 1 00000008", mem_req, mem_addr);
        end
    endtask

    task automatic test_jump_abort();
        cyc();
        send_bytes(32'hDEADBEEF, 2, 1'b0);
        jump_en = 1'b1;
        jump_pc = 32'h100;
        cyc();
        jump_en = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_drop: got req=%b valid=%b expected 0 0", mem_req, inst_valid);
        end
        mem_byte       = 8'hEE;
        mem_byte_valid = 1'b1;
        cyc();
        vectors++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_cycle: got req=%b valid=%b expected 0 0", mem_req, inst_valid);
        end
        cyc();
        mem_byte_valid = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_redirect: got req=%b addr=%h valid=%b expected 1 00000100 0", mem_req, mem_addr, inst_valid);
        end
        cyc();
        send_bytes(32'h12345678, 4, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h12345678 || pc_out !== 32'h100) begin
            miscompares++; $display("[TB] FAIL abort_target_inst: got valid=%b inst=%h pc=%h expected 1 12345678 00000100", inst_valid, inst, pc_out);
        end
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            miscompares++; $display("[TB] FAIL abort_next_addr: got req=%b addr=%h expected 1 00000104", mem_req, mem_addr);
        end
    endtask

    task automatic test_jump_last_byte();
        cyc();
        send_bytes(32'hCAFEBABE, 3, 1'b0);
        mem_byte       = 8'hCA;
        mem_byte_valid = 1'b1;
        jump_en        = 1'b1;
        jump_pc        = 32'h200;
        cyc();
        jump_en        = 1'b0;
        mem_byte_valid = 1'b0;
        vectors++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL lastbyte_discard: got valid=%b req=%b expected 0 0", inst_valid, mem_req);
        end
        cyc();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL lastbyte_abort: got valid=%b expected 0", inst_valid);
        end
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL lastbyte_target: got req=%b addr=%h valid=%b expected 1 00000200 0", mem_req, mem_addr, inst_valid);
        end
    endtask

    task automatic test_cache_loop();
        cyc();
        send_bytes(32'h00000213, 4, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000213 || pc_out !== 32'h200) begin
            miscompares++; $display("[TB] FAIL loop_200: got valid=%b inst=%h pc=%h expected 1 00000213 00000200", inst_valid, inst, pc_out);
        end
        jump_en = 1'b1;
        jump_pc = 32'h0;
        cyc();
        jump_en = 1'b0;
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL loop_miss0: got req=%b addr=%h expected 1 00000000", mem_req, mem_addr);
        end
        cyc();
        send_bytes(32'h00000013, 4, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || pc_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL loop_inst0: got valid=%b inst=%h pc=%h expected 1 00000013 00000000", inst_valid, inst, pc_out);
        end
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            miscompares++; $display("[TB] FAIL loop_miss4: got req=%b addr=%h expected 1 00000004", mem_req, mem_addr);
        end
        cyc();
        send_bytes(32'h00A00093, 4, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00A00093 || pc_out !== 32'h4) begin
            miscompares++; $display("[TB] FAIL loop_inst4: got valid=%b inst=%h pc=%h expected 1 00a00093 00000004", inst_valid, inst, pc_out);
        end
        jump_en = 1'b1;
        jump_pc = 32'h0;
        cyc();
        jump_en = 1'b0;
        vectors++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL loop_jump: got valid=%b req=%b expected 0 0", inst_valid, mem_req);
        end
        cyc();
`ifdef ICACHE_EN
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || pc_out !== 32'h0 || mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL hit0: got valid=%b inst=%h pc=%h req=%b expected 1 00000013 00000000 0", inst_valid, inst, pc_out, mem_req);
        end
        cyc();
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00A00093 || pc_out !== 32'h4 || mem_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL hit4: got valid=%b inst=%h pc=%h req=%b expected 1 00a00093 00000004 0", inst_valid, inst, pc_out, mem_req);
        end
`else
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL nocache_refetch: got req=%b addr=%h valid=%b expected 1 00000000 0", mem_req, mem_addr, inst_valid);
        end
`endif
    endtask

    task automatic test_pc_wrap();
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFFFFFC) begin
            miscompares++; $display("[TB] FAIL wrap_req: got req=%b addr=%h expected 1 fffffffc", w_req, w_addr);
        end
        cyc();
        send_bytes(32'h00000013, 4, 1'b1);
        vectors++;
        if (w_inst_valid !== 1'b1 || w_inst !== 32'h00000013 || w_pc_out !== 32'hFFFFFFFC) begin
            miscompares++; $display("[TB] FAIL wrap_inst: got valid=%b inst=%h pc=%h expected 1 00000013 fffffffc", w_inst_valid, w_inst, w_pc_out);
        end
        cyc();
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL wrap_next: got req=%b addr=%h expected 1 00000000", w_req, w_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        cyc();
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midreset_pre: got req=%b expected 1", mem_req);
        end
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0 || pc_out !== 32'h0) begin
            miscompares++; $display("[TB] FAIL midreset_async: got req=%b addr=%h valid=%b inst=%h pc=%h expected all 0", mem_req, mem_addr, inst_valid, inst, pc_out);
        end
        cyc();
        rstn = 1'b1;
        cyc();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_restart: got req=%b addr=%h valid=%b expected 1 00000000 0", mem_req, mem_addr, inst_valid);
        end
    endtask

    // Sequence of directed scenarios, ending with the summary.
    initial begin
        vectors        = 0;
        miscompares    = 0;
        rstn           = 1'b0;
        stall          = 1'b0;
        jump_en        = 1'b0;
        jump_pc        = 32'h0;
        mem_byte       = 8'h00;
        mem_byte_valid = 1'b0;
        w_stall        = 1'b0;
        w_jump_en      = 1'b0;
        w_jump_pc      = 32'h0;
        w_byte         = 8'h00;
        w_byte_valid   = 1'b0;

        test_reset();
        test_first_fetch();
        test_stall();
        test_jump_abort();
        test_jump_last_byte();
        test_cache_loop();
        test_pc_wrap();
        test_reset_mid_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
